// File: rtl/mc_pkg_112.sv
// =============================================================================
// Module      : mc_pkg_112
// Description : Shared types and encodings for the multi-cycle MIPS control unit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mc_pkg_112;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;

    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_sub  = 3'b001;
    localparam logic [2:0] c_alu_and  = 3'b010;
    localparam logic [2:0] c_alu_or   = 3'b011;
    localparam logic [2:0] c_alu_slt  = 3'b100;
    localparam logic [2:0] c_alu_sltu = 3'b101;

    // Bit order matches the flattened output port order of the top.
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       mem_wr;
        logic       ext_op;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctr;
        logic       illegal;
        logic       mem_timeout;
    } ctrl_t;

    function automatic logic is_itype_op(input logic [5:0] op);
        return (op == c_op_addiu) || (op == c_op_ori) || (op == c_op_lw) ||
               (op == c_op_sw)    || (op == c_op_beq) || (op == c_op_j);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_aludec_112.sv
// =============================================================================
// Module      : mc_aludec_112
// Description : R-type function decoder: func -> ALU operation plus legal flag.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mc_aludec_112
    import mc_pkg_112::*;
(
    input  logic [5:0] i_func,
    output logic [2:0] o_aluctr,
    output logic       o_legal
);

    always_comb begin
        o_aluctr = c_alu_add;
        o_legal  = 1'b1;
        case (i_func)
            c_fn_addu: o_aluctr = c_alu_add;
            c_fn_subu: o_aluctr = c_alu_sub;
            c_fn_and:  o_aluctr = c_alu_and;
            c_fn_or:   o_aluctr = c_alu_or;
            c_fn_slt:  o_aluctr = c_alu_slt;
            c_fn_sltu: o_aluctr = c_alu_sltu;
            default:   o_legal  = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_112.sv
// =============================================================================
// Module      : mc_control_112
// Description : Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory
//               ready handshakes, bounded wait timeout and illegal-op flag.
//               Optional macro MC_CONTROL_PERF_EN adds cycle/instruction counters.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mc_control_112
    import mc_pkg_112::*;
#(
    parameter int WAIT_MAX = 16
`ifdef MC_CONTROL_PERF_EN
    , parameter int CNT_W  = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       ALUsrc,
    output logic       MemtoReg,
    output logic       RegWr,
    output logic       MemWr,
    output logic       ExtOp,
    output logic       Branch,
    output logic       Jump,
    output logic [2:0] ALUctr,
    output logic       illegal,
    output logic       mem_timeout
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`else
`endif
);

    localparam int                c_wcnt_w   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_wcnt_w-1:0] c_wait_last = c_wcnt_w'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wcnt_w-1:0] r_wait_cnt;
    logic [5:0]          r_op;
    logic [5:0]          r_func;
    ctrl_t               w_ctrl;
    logic [2:0]          w_fn_aluctr;
    logic                w_fn_legal;
    logic                w_legal;
    logic                w_wait_last;

    mc_aludec_112 u_aludec (
        .i_func   (r_func),
        .o_aluctr (w_fn_aluctr),
        .o_legal  (w_fn_legal)
    );

    assign w_legal     = (r_op == c_op_rtype) ? w_fn_legal : is_itype_op(r_op);
    assign w_wait_last = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IF;
            r_wait_cnt <= '0;
            r_op       <= '0;
            r_func     <= '0;
        end else begin
            r_state <= w_state_nxt;
            // An IF->IF timeout is a re-entry, so it restarts the count too.
            if ((w_state_nxt != r_state) || w_ctrl.mem_timeout)
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + c_wcnt_w'(1);
            if ((r_state == ST_IF) && imem_ready) begin
                r_op   <= op;
                r_func <= func;
            end
        end
    end

    always_comb begin
        w_ctrl      = '0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IF: begin
                w_ctrl.imem_req = 1'b1;
                if (imem_ready) begin
                    w_ctrl.ir_wr = 1'b1;
                    w_ctrl.pc_wr = 1'b1;
                    w_state_nxt  = ST_ID;
                end else if (w_wait_last) begin
                    w_ctrl.mem_timeout = 1'b1;
                    w_state_nxt        = ST_IF;
                end
            end
            ST_ID: begin
                if (!w_legal) begin
                    w_ctrl.illegal = 1'b1;
                    w_state_nxt    = ST_IF;
                end else if (r_op == c_op_j) begin
                    w_ctrl.jump  = 1'b1;
                    w_ctrl.pc_wr = 1'b1;
                    w_state_nxt  = ST_IF;
                end else begin
                    w_state_nxt = ST_EX;
                end
            end
            ST_EX: begin
                w_state_nxt = ST_WB;
                case (r_op)
                    c_op_beq: begin
                        w_ctrl.branch  = 1'b1;
                        w_ctrl.alu_ctr = c_alu_sub;
                        w_ctrl.pc_wr   = zero;
                        w_state_nxt    = ST_IF;
                    end
                    c_op_lw, c_op_sw: begin
                        w_ctrl.alu_src = 1'b1;
                        w_ctrl.ext_op  = 1'b1;
                        w_ctrl.alu_ctr = c_alu_add;
                        w_state_nxt    = ST_MEM;
                    end
                    c_op_addiu: begin
                        w_ctrl.alu_src = 1'b1;
                        w_ctrl.ext_op  = 1'b1;
                        w_ctrl.alu_ctr = c_alu_add;
                    end
                    c_op_ori: begin
                        w_ctrl.alu_src = 1'b1;
                        w_ctrl.alu_ctr = c_alu_or;
                    end
                    c_op_rtype: w_ctrl.alu_ctr = w_fn_aluctr;
                    default:    w_state_nxt    = ST_IF;
                endcase
            end
            ST_MEM: begin
                w_ctrl.dmem_req = 1'b1;
                w_ctrl.mem_wr   = (r_op == c_op_sw);
                if (dmem_ready) begin
                    w_state_nxt = (r_op == c_op_sw) ? ST_IF : ST_WB;
                end else if (w_wait_last) begin
                    w_ctrl.mem_wr      = 1'b0;
                    w_ctrl.mem_timeout = 1'b1;
                    w_state_nxt        = ST_IF;
                end
            end
            ST_WB: begin
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.reg_dst    = (r_op == c_op_rtype);
                w_ctrl.mem_to_reg = (r_op == c_op_lw);
                w_state_nxt       = ST_IF;
            end
            default: w_state_nxt = ST_IF;
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    assign {imem_req, dmem_req, PCWr, IRWr, RegDst, ALUsrc, MemtoReg, RegWr,
            MemWr, ExtOp, Branch, Jump, ALUctr, illegal, mem_timeout} = rst_n ? w_ctrl : '0;

`ifdef MC_CONTROL_PERF_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    assign w_retire = (w_state_nxt == ST_IF) && (r_state != ST_IF) &&
                      !w_ctrl.illegal && !w_ctrl.mem_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire)
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    // Counters are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_112.sv
// =============================================================================
// Module      : tb_mc_control_112
// Description : Scoreboard testbench for mc_control_112 (WAIT_MAX=4).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mc_control_112;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 32;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADDU = 6'b100001;

    localparam logic [16:0] M_IMEM   = 17'h1_0000, M_DMEM  = 17'h0_8000, M_PCWR  = 17'h0_4000;
    localparam logic [16:0] M_IRWR   = 17'h0_2000, M_RDST  = 17'h0_1000, M_ASRC  = 17'h0_0800;
    localparam logic [16:0] M_M2R    = 17'h0_0400, M_RGWR  = 17'h0_0200, M_MEMWR = 17'h0_0100;
    localparam logic [16:0] M_EXT    = 17'h0_0080, M_BR    = 17'h0_0040, M_JMP   = 17'h0_0020;
    localparam logic [16:0] M_ILL    = 17'h0_0002, M_TO    = 17'h0_0001;
    localparam logic [16:0] V_FETCH  = M_IMEM | M_PCWR | M_IRWR;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, func;
    logic       zero, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, PCWr, IRWr, RegDst, ALUsrc, MemtoReg, RegWr;
    logic       MemWr, ExtOp, Branch, Jump, illegal, mem_timeout;
    logic [2:0] ALUctr;
`ifdef MC_CONTROL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;
    int unsigned      exp_cyc;
`endif

    typedef struct {
        logic [16:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    logic     sb_en = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       exp_instr = 0;

    always #5 clk = ~clk;

    mc_control_112 #(
        .WAIT_MAX (WAIT_MAX)
`ifdef MC_CONTROL_PERF_EN
        , .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .func        (func),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .RegDst      (RegDst),
        .ALUsrc      (ALUsrc),
        .MemtoReg    (MemtoReg),
        .RegWr       (RegWr),
        .MemWr       (MemWr),
        .ExtOp       (ExtOp),
        .Branch      (Branch),
        .Jump        (Jump),
        .ALUctr      (ALUctr),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
`ifdef MC_CONTROL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    function automatic logic [16:0] alu(input logic [2:0] a);
        return {12'd0, a, 2'd0};
    endfunction

    function automatic logic [16:0] act_vec();
        return {imem_req, dmem_req, PCWr, IRWr, RegDst, ALUsrc, MemtoReg, RegWr,
                MemWr, ExtOp, Branch, Jump, ALUctr, illegal, mem_timeout};
    endfunction

`ifdef MC_CONTROL_PERF_EN
    always @(posedge clk or negedge rst_n)
        if (!rst_n) exp_cyc <= 0;
        else        exp_cyc <= exp_cyc + 1;
`endif

    // One cycle of stimulus: inputs applied at negedge, expected outputs queued.
    task automatic drive(input logic rn, input logic ir, input logic dr, input logic z,
                         input logic [5:0] o, input logic [5:0] f,
                         input logic [16:0] e, input string nm);
        sb_item_t it;
        @(negedge clk);
        rst_n = rn; imem_ready = ir; dmem_ready = dr; zero = z; op = o; func = f;
        it.exp  = e;
        it.name = nm;
        sb_q.push_back(it);
    endtask

    always @(negedge clk) begin
        sb_item_t it;
        if (sb_en) begin
            #1;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow at %0t: actual=%b required=<queued entry>", $time, act_vec());
            end else begin
                it = sb_q.pop_front();
                if (act_vec() !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s at %0t: actual=%b required=%b", it.name, $time, act_vec(), it.exp);
                end
            end
        end
    end

    task automatic test_reset();
        drive(0, 0, 0, 0, OP_SW, 6'd0, 17'd0, "rst_held");
        drive(0, 1, 1, 1, OP_SW, 6'd0, 17'd0, "rst_held_inputs_hi");
        drive(1, 1, 0, 0, OP_SW, 6'd0, V_FETCH, "sw_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "sw_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "sw_ex");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_DMEM | M_MEMWR, "sw_mem_wait");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (act_vec() !== 17'd0) begin
            n_fail++;
            $display("FAIL rst_mid_mem: actual=%b required=%b", act_vec(), 17'd0);
        end
        drive(1, 0, 0, 0, OP_R, 6'd0, M_IMEM, "post_rst_if");
    endtask

    task automatic test_addu();
        drive(1, 1, 0, 0, OP_R, FN_ADDU, V_FETCH, "addu_if");
        drive(1, 1, 1, 1, OP_BAD, 6'd0, 17'd0, "addu_id");
        drive(1, 1, 1, 1, OP_BAD, 6'd0, alu(3'b000), "addu_ex");
        drive(1, 1, 1, 1, OP_BAD, 6'd0, M_RGWR | M_RDST, "addu_wb");
        exp_instr += 1;
    endtask

    task automatic test_lw_wait();
        drive(1, 1, 0, 0, OP_LW, 6'd0, V_FETCH, "lw_if");
        drive(1, 1, 0, 0, OP_R, 6'd0, 17'd0, "lw_id");
        drive(1, 1, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "lw_ex");
        for (int i = 0; i < 3; i++)
            drive(1, 1, 0, 0, OP_R, 6'd0, M_DMEM, "lw_mem_wait");
        drive(1, 1, 1, 0, OP_R, 6'd0, M_DMEM, "lw_mem_ready");
        drive(1, 1, 0, 0, OP_R, 6'd0, M_RGWR | M_M2R, "lw_wb");
        exp_instr += 1;
    endtask

    task automatic test_beq();
        drive(1, 1, 0, 1, OP_BEQ, 6'd0, V_FETCH, "beq1_if");
        drive(1, 0, 0, 1, OP_R, 6'd0, 17'd0, "beq1_id");
        drive(1, 0, 0, 1, OP_R, 6'd0, M_BR | M_PCWR | alu(3'b001), "beq_taken_ex");
        drive(1, 1, 0, 1, OP_BEQ, 6'd0, V_FETCH, "beq2_if");
        drive(1, 0, 0, 1, OP_R, 6'd0, 17'd0, "beq2_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_BR | alu(3'b001), "beq_not_taken_ex");
        exp_instr += 2;
    endtask

    task automatic test_other_ops();
        logic [5:0] fns [5];
        logic [2:0] alus [5];
        fns[0] = 6'b100011; alus[0] = 3'b001;
        fns[1] = 6'b100100; alus[1] = 3'b010;
        fns[2] = 6'b100101; alus[2] = 3'b011;
        fns[3] = 6'b101010; alus[3] = 3'b100;
        fns[4] = 6'b101011; alus[4] = 3'b101;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, OP_R, fns[i], V_FETCH, "r_if");
            drive(1, 0, 0, 0, OP_LW, 6'd0, 17'd0, "r_id");
            drive(1, 0, 0, 0, OP_LW, 6'd0, alu(alus[i]), "r_ex");
            drive(1, 0, 0, 0, OP_LW, 6'd0, M_RGWR | M_RDST, "r_wb");
        end
        drive(1, 1, 0, 0, OP_ORI, 6'd0, V_FETCH, "ori_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "ori_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | alu(3'b011), "ori_ex");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_RGWR, "ori_wb");
        drive(1, 1, 0, 0, OP_ADDIU, 6'd0, V_FETCH, "addiu_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "addiu_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "addiu_ex");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_RGWR, "addiu_wb");
        drive(1, 1, 0, 0, OP_SW, 6'd0, V_FETCH, "sw_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "sw_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "sw_ex");
        drive(1, 0, 1, 0, OP_R, 6'd0, M_DMEM | M_MEMWR, "sw_mem");
        drive(1, 1, 0, 0, OP_J, 6'd0, V_FETCH, "j_if");
        drive(1, 1, 0, 0, OP_R, 6'd0, M_JMP | M_PCWR, "j_id");
        exp_instr += 9;
    endtask

    task automatic test_timeouts();
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, OP_J, 6'd0, M_IMEM, "if_wait");
        drive(1, 0, 0, 0, OP_J, 6'd0, M_IMEM | M_TO, "if_timeout");
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, OP_J, 6'd0, M_IMEM, "if_rewait");
        drive(1, 1, 0, 0, OP_J, 6'd0, V_FETCH, "if_ready_wins");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_JMP | M_PCWR, "j_id");
        drive(1, 1, 0, 0, OP_SW, 6'd0, V_FETCH, "swto_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "swto_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "swto_ex");
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, OP_R, 6'd0, M_DMEM | M_MEMWR, "swto_mem_wait");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_DMEM | M_TO, "swto_timeout");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_IMEM, "swto_back_if");
        drive(1, 1, 0, 0, OP_LW, 6'd0, V_FETCH, "lwrw_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, 17'd0, "lwrw_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ASRC | M_EXT, "lwrw_ex");
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, OP_R, 6'd0, M_DMEM, "lwrw_mem_wait");
        drive(1, 0, 1, 0, OP_R, 6'd0, M_DMEM, "lwrw_ready_wins");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_RGWR | M_M2R, "lwrw_wb");
        exp_instr += 2;
    endtask

    task automatic test_illegal();
        drive(1, 1, 0, 0, OP_BAD, 6'd0, V_FETCH, "bad_op_if");
`ifdef MC_CONTROL_PERF_EN
        #2;
        n_checks++;
        if (instr_cnt !== CNT_W'(exp_instr)) begin
            n_fail++;
            $display("FAIL instr_cnt_before: actual=%0d required=%0d", instr_cnt, exp_instr);
        end
`endif
        drive(1, 0, 0, 1, OP_R, 6'd0, M_ILL, "bad_op_id");
        drive(1, 1, 0, 0, OP_R, 6'b000000, V_FETCH, "bad_fn_if");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_ILL, "bad_fn_id");
        drive(1, 0, 0, 0, OP_R, 6'd0, M_IMEM, "bad_back_if");
`ifdef MC_CONTROL_PERF_EN
        #2;
        n_checks++;
        if (instr_cnt !== CNT_W'(exp_instr)) begin
            n_fail++;
            $display("FAIL instr_cnt_after_illegal: actual=%0d required=%0d", instr_cnt, exp_instr);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        op = '0; func = '0;
        sb_en = 1'b1;
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_other_ops();
        test_timeouts();
        test_illegal();
        #2;
        sb_en = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: actual=%0d required=0", sb_q.size());
        end
`ifdef MC_CONTROL_PERF_EN
        n_checks++;
        if (cycle_cnt !== CNT_W'(exp_cyc)) begin
            n_fail++;
            $display("FAIL cycle_cnt: actual=%0d required=%0d", cycle_cnt, exp_cyc);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
